mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin access of two requesters to one shared signed 4x4 multiplier
module mult_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_prod,
  input  logic       mul_ovf,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_prod,
  output logic       rsp_ovf,
  input  logic       rsp_ready,
  output logic       busy,
  output logic [7:0] ops_done
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // grants only in IDLE; last==1 hands a tie to requester 0
  always_comb begin
    gnt0 = rst_n && state == IDLE && req0 && (!req1 || last);
    gnt1 = rst_n && state == IDLE && req1 && (!req0 || !last);
    state_nx = state == IDLE   ? ((gnt0 || gnt1) ? SETTLE : IDLE) :
               state == SETTLE ? (cnt == 4'd1 ? RESP : SETTLE) :
                                 (rsp_ready ? IDLE : RESP);
  end
  // operand latch, settle countdown, response capture and completion count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      cnt      <= '0;
      last     <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_prod <= '0;
      rsp_ovf  <= 1'b0;
      ops_done <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        mul_a <= gnt1 ? a1 : a0;
        mul_b <= gnt1 ? b1 : b0;
        cnt   <= 4'(WAIT_CYCLES);
        last  <= gnt1;
      end
      if (state == SETTLE) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          rsp_prod <= mul_prod;
          rsp_ovf  <= mul_ovf;
          rsp_id   <= last;
        end
      end
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 8'd1;
    end
  end
endmodule
